// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined adder-subtractor:
//   - op_t      : operation encoding (OP_ADD, OP_SUB, OP_ACC, OP_CLR)
//   - is_acc_op : true for ops that read or write the accumulator
//   - ovfl_calc : two's-complement overflow from the operand and result signs
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    // ACC and CLR both touch the accumulator, so they are the ops that
    // must be kept apart in the pipeline.
    function automatic logic is_acc_op(input op_t o);
        return (o == OP_ACC) || (o == OP_CLR);
    endfunction

    // Overflow happens when both effective operands share a sign and the
    // result sign differs from it. The B sign is the already-inverted one
    // for SUB, so one expression covers ADD, SUB and ACC.
    function automatic logic ovfl_calc(input logic sign_a,
                                       input logic sign_b,
                                       input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Purely combinational W-bit adder with carry in and carry out. It is used
// for the low half of the sum in the first stage and the high half in the
// second stage.
// Ports:
//   x, y  : W-bit addends
//   cin   : carry in
//   sum   : W-bit sum
//   cout  : carry out of bit W-1
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Two-stage pipelined signed/unsigned adder-subtractor with an internal
// accumulator. It uses a valid/ready handshake on both sides.
//   Stage 1: low-half sum plus its carry, the high halves of the effective
//            operands (B already inverted for SUB), and the op.
//   Stage 2: high-half sum, then the result/carry/ovfl/zero output register.
// Ops: ADD a+b, SUB a+~b+1, ACC acc+a, CLR (result = acc = ACC_INIT).
//
// Build option: define ADDSUB_SAT_EN to clamp overflowing results to the
// most positive or most negative value. The clamped value is also written
// into acc, and zero is taken from it. Otherwise the result wraps.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, op)
//   out_valid/out_ready : result handshake (result, carry, ovfl, zero)
// -----------------------------------------------------------------------------
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovfl,
    output logic             zero
);

    localparam int HALF = WIDTH / 2;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // ---------------------------------------------------------------- state
    logic             s1_valid_reg;
    logic [HALF-1:0]  s1_lo_reg;
    logic             s1_c_reg;
    logic [HALF-1:0]  s1_ahi_reg;
    logic [HALF-1:0]  s1_bhi_reg;
    op_t              s1_op_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             ovfl_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] acc_reg;

    // ----------------------------------------------------------- handshake
    op_t  op_in;
    logic hazard;
    logic s2_free;
    logic s1_adv;
    logic accept;

    assign op_in = op_t'(op);

    // Two back-to-back accumulator ops would read acc before the first one
    // writes it back. The second op is held until the first has left S1.
    // ADD/SUB never read acc, so they are never held.
    assign hazard   = is_acc_op(op_in) & s1_valid_reg & is_acc_op(s1_op_reg);
    assign s2_free  = ~out_valid_reg | out_ready;
    assign s1_adv   = s1_valid_reg & s2_free;
    assign in_ready = (~s1_valid_reg | s1_adv) & ~hazard;
    assign accept   = in_valid & in_ready;

    // ------------------------------------------ stage 1: operand select + low
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic [HALF-1:0]  lo_sum;
    logic             lo_cout;

    always_comb begin
        eff_a   = a;
        eff_b   = b;
        eff_cin = 1'b0;
        case (op_in)
            OP_ADD: ;
            OP_SUB: begin
                eff_b   = ~b;
                eff_cin = 1'b1;
            end
            OP_ACC: begin
                eff_a = acc_reg;
                eff_b = a;
            end
            OP_CLR: begin
                // The result is forced in stage 2. These operands only keep
                // the datapath quiet.
                eff_a = ACC_INIT;
                eff_b = '0;
            end
            default: ;
        endcase
    end

    addsub_slice #(.W(HALF)) u_lo (
        .x    (eff_a[HALF-1:0]),
        .y    (eff_b[HALF-1:0]),
        .cin  (eff_cin),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_lo_reg    <= '0;
            s1_c_reg     <= 1'b0;
            s1_ahi_reg   <= '0;
            s1_bhi_reg   <= '0;
            s1_op_reg    <= OP_ADD;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_lo_reg    <= lo_sum;
                s1_c_reg     <= lo_cout;
                s1_ahi_reg   <= eff_a[WIDTH-1:HALF];
                s1_bhi_reg   <= eff_b[WIDTH-1:HALF];
                s1_op_reg    <= op_in;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------ stage 2: high half + flags
    logic [HALF-1:0]  hi_sum;
    logic             hi_cout;
    logic [WIDTH-1:0] raw_sum;
    logic             raw_ovfl;
    logic [WIDTH-1:0] fin_result;
    logic             fin_carry;
    logic             fin_ovfl;
    logic             fin_zero;

    addsub_slice #(.W(HALF)) u_hi (
        .x    (s1_ahi_reg),
        .y    (s1_bhi_reg),
        .cin  (s1_c_reg),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    assign raw_sum  = {hi_sum, s1_lo_reg};
    assign raw_ovfl = ovfl_calc(s1_ahi_reg[HALF-1], s1_bhi_reg[HALF-1],
                                hi_sum[HALF-1]);

    always_comb begin
        fin_result = raw_sum;
        fin_carry  = hi_cout;
        fin_ovfl   = raw_ovfl;
        if (s1_op_reg == OP_CLR) begin
            fin_result = ACC_INIT;
            fin_carry  = 1'b0;
            fin_ovfl   = 1'b0;
        end
`ifdef ADDSUB_SAT_EN
        else if (raw_ovfl) begin
            // Both operands share a sign on overflow. That sign tells which
            // rail was crossed.
            fin_result = s1_ahi_reg[HALF-1] ? SAT_NEG : SAT_POS;
        end
`endif
    end

    assign fin_zero = (fin_result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            ovfl_reg      <= 1'b0;
            zero_reg      <= 1'b0;
            acc_reg       <= ACC_INIT;
        end else begin
            if (s1_adv) begin
                out_valid_reg <= 1'b1;
                result_reg    <= fin_result;
                carry_reg     <= fin_carry;
                ovfl_reg      <= fin_ovfl;
                zero_reg      <= fin_zero;
                // acc is written when the op moves into S2. This is why
                // the hazard only has to look at S1.
                if (is_acc_op(s1_op_reg)) begin
                    acc_reg <= fin_result;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign ovfl      = ovfl_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
// Directed, table-driven bench for addsub_pipe with WIDTH=8 and ACC_INIT=0.
// It covers single-beat op vectors with a latency check, a back-pressured
// random stream against a scoreboard, the accumulator bubble sequences, and
// reset while beats are in flight. Expected values follow ADDSUB_SAT_EN when
// it is defined.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;

    localparam logic [1:0] C_ADD = 2'b00;
    localparam logic [1:0] C_SUB = 2'b01;
    localparam logic [1:0] C_ACC = 2'b10;
    localparam logic [1:0] C_CLR = 2'b11;

`ifdef ADDSUB_SAT_EN
    localparam logic [7:0] R_6D45 = 8'h7F;
    localparam logic [7:0] R_809C = 8'h80;
    localparam logic [7:0] R_8001 = 8'h80;
    localparam logic [7:0] R_ACC2 = 8'h7F;
    localparam logic [7:0] R_ACC3 = 8'h7F;
    localparam logic       O_ACC3 = 1'b1;
`else
    localparam logic [7:0] R_6D45 = 8'hB2;
    localparam logic [7:0] R_809C = 8'h1C;
    localparam logic [7:0] R_8001 = 8'h7F;
    localparam logic [7:0] R_ACC2 = 8'h82;
    localparam logic [7:0] R_ACC3 = 8'h83;
    localparam logic       O_ACC3 = 1'b0;
`endif

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       ovfl;
    logic       zero;

    int checks = 0;
    int errors = 0;
    vec_t sq[$];

    addsub_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .ovfl      (ovfl),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour for ADD/SUB beats in the random stream.
    function automatic vec_t mk(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        vec_t v;
        logic [8:0] s;
        logic ov;
        if (o == C_SUB) begin
            s  = {1'b0, x} + {1'b0, ~y} + 9'd1;
            ov = (x[7] != y[7]) && (s[7] != x[7]);
        end else begin
            s  = {1'b0, x} + {1'b0, y};
            ov = (x[7] == y[7]) && (s[7] != x[7]);
        end
        v.op  = o;
        v.a   = x;
        v.b   = y;
        v.res = s[7:0];
        v.c   = s[8];
        v.o   = ov;
`ifdef ADDSUB_SAT_EN
        if (ov) v.res = x[7] ? 8'h80 : 8'h7F;
`endif
        v.z = (v.res == 8'h00);
        return v;
    endfunction

    task automatic push(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r, input logic c, input logic ov, input logic z);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.c = c; v.o = ov; v.z = z;
        sq.push_back(v);
    endtask

    // Plays the beats in sq and checks every output beat in order. The task
    // is entered 1 time unit after a rising edge. With bp set, out_ready is
    // low one cycle in three.
    task automatic stream(input string tag, input bit bp, output int stalls);
        int n, sent, got, cyc;
        bit held;
        logic [11:0] held_val;
        n = sq.size(); sent = 0; got = 0; cyc = 0; held = 1'b0; held_val = '0;
        stalls = 0;
        out_ready = 1'b1;
        in_valid = (n > 0);
        if (n > 0) begin op = sq[0].op; a = sq[0].a; b = sq[0].b; end
        while (got < n && cyc < 200) begin
            @(negedge clk);
            if (held) chk({tag, "_hold"}, {out_valid, result, carry, ovfl, zero}, held_val);
            held = out_valid && !out_ready;
            if (held) held_val = {out_valid, result, carry, ovfl, zero};
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                $display("%s txn %0d op=%0d a=%02h b=%02h -> result=%02h c=%0b o=%0b z=%0b",
                         tag, got, sq[got].op, sq[got].a, sq[got].b, result, carry, ovfl, zero);
                chk({tag, "_result"}, result, sq[got].res);
                chk({tag, "_carry"},  carry,  sq[got].c);
                chk({tag, "_ovfl"},   ovfl,   sq[got].o);
                chk({tag, "_zero"},   zero,   sq[got].z);
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (sent < n) begin
                in_valid = 1'b1; op = sq[sent].op; a = sq[sent].a; b = sq[sent].b;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = bp ? (cyc % 3 != 2) : 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, got, n);
    endtask

    initial begin
        vec_t tbl[8];
        int stalls;

        tbl[0] = '{C_SUB, 8'h00, 8'h01, 8'hFF,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{C_ADD, 8'h6D, 8'h45, R_6D45, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{C_ADD, 8'h80, 8'h9C, R_809C, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{C_SUB, 8'h06, 8'h01, 8'h05,  1'b1, 1'b0, 1'b0};
        tbl[4] = '{C_ADD, 8'hFF, 8'h01, 8'h00,  1'b1, 1'b0, 1'b1};
        tbl[5] = '{C_SUB, 8'h80, 8'h01, R_8001, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{C_ADD, 8'h0F, 8'h01, 8'h10,  1'b0, 1'b0, 1'b0};
        tbl[7] = '{C_SUB, 8'h10, 8'h10, 8'h00,  1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = C_ADD;

        // Reset state.
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", {carry, ovfl, zero}, 3'b000);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Single beats: out_valid must be low after one edge and high after two.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec_latency", out_valid, 1'b0);
            @(posedge clk); #1;
            $display("vec %0d op=%0d a=%02h b=%02h -> v=%0b result=%02h c=%0b o=%0b z=%0b",
                     i, tbl[i].op, tbl[i].a, tbl[i].b, out_valid, result, carry, ovfl, zero);
            chk("vec_out_valid", out_valid, 1'b1);
            chk("vec_result", result, tbl[i].res);
            chk("vec_carry", carry, tbl[i].c);
            chk("vec_ovfl", ovfl, tbl[i].o);
            chk("vec_zero", zero, tbl[i].z);
            @(posedge clk); #1;
        end

        // Back-pressured random ADD/SUB stream.
        sq.delete();
        for (int i = 0; i < 10; i++) begin
            sq.push_back(mk($urandom_range(0, 1) ? C_SUB : C_ADD,
                            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
        end
        stream("bp", 1'b1, stalls);
        chk("bp_in_ready_fell", (stalls > 0), 1'b1);

        // Accumulator chain: one bubble before each ACC.
        sq.delete();
        push(C_CLR, 8'h00, 8'h00, 8'h00,   1'b0, 1'b0,   1'b1);
        push(C_ACC, 8'h05, 8'hAA, 8'h05,   1'b0, 1'b0,   1'b0);
        push(C_ACC, 8'h7D, 8'h55, R_ACC2,  1'b0, 1'b1,   1'b0);
        push(C_ACC, 8'h01, 8'hFF, R_ACC3,  1'b0, O_ACC3, 1'b0);
        stream("acc", 1'b0, stalls);
        chk("acc_bubbles", stalls, 3);

        // Mixed hazard: an ADD right after an ACC goes through with no bubble.
        sq.delete();
        push(C_CLR, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        push(C_ACC, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
        push(C_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        stream("mix", 1'b0, stalls);
        chk("mix_bubbles", stalls, 1);

        // Reset with two beats in flight (acc is 0x10 here).
        out_ready = 1'b0;
        in_valid = 1'b1; op = C_ADD; a = 8'h01; b = 8'h02;
        @(posedge clk); #1;
        a = 8'h03; b = 8'h04;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1'b1);
        chk("pre_rst_result", result, 8'h03);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_result", result, 8'h00);
        chk("mid_rst_flags", {carry, ovfl, zero}, 3'b000);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        sq.delete();
        push(C_ACC, 8'h03, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
        stream("post_rst_acc", 1'b0, stalls);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
